// File: rtl/byte_mem_loader_if.sv
// Host-side byte streams of byte_mem_loader: program bytes in, memory image out.
interface byte_mem_loader_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/byte_mem_loader.sv
// Program/data RAM beside the byte computer core: host load, core run, image dump.
// Optional CLEAR_ON_LOAD_EN inserts a zero-fill pass over the RAM before each load.
module byte_mem_loader #(
    parameter int ADDR_W = 5,
    parameter int CYC_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_req,
    byte_mem_loader_if.slave    host,
    output logic                cpu_rst_n,
    output logic                cpu_start,
    input  logic                cpu_halt,
    input  logic                cpu_we,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [7:0]          cpu_wdata,
    output logic [7:0]          cpu_rdata,
    output logic                busy,
    output logic [CYC_W-1:0]    run_cycles
);
    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH-1);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_LOAD, S_RUN, S_DUMP} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W:0]    ptr_q, ptr_d;
    logic [CYC_W-1:0]   run_cycles_q, run_cycles_d;
    logic               rd_vld_q, rd_vld_d;
    logic               rd_last_q, rd_last_d;
    logic               out_valid_q, out_valid_d;
    logic [7:0]         out_data_q, out_data_d;
    logic               out_last_q, out_last_d;
    logic [7:0]         rd_q;

    logic [7:0]         mem [DEPTH];
    logic               we, rd_en;
    logic [ADDR_W-1:0]  waddr, rd_addr;
    logic [7:0]         wdata;
    logic               accept, issue, out_load, out_hs;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (load_req) begin
`ifdef CLEAR_ON_LOAD_EN
                state_d = S_CLEAR;
`else
                state_d = S_LOAD;
`endif
            end
            S_CLEAR: if (ptr_q[ADDR_W-1:0] == LAST_A) state_d = S_LOAD;
            S_LOAD:  if (accept && (host.in_last || ptr_q[ADDR_W-1:0] == LAST_A)) state_d = S_RUN;
            // run_cycles is still zero in the first RUN cycle, which masks a stale halt
            S_RUN:   if (cpu_halt && run_cycles_q != '0) state_d = S_DUMP;
            S_DUMP:  if (out_hs && out_last_q) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        host.in_ready = (state_q == S_LOAD);
        busy          = (state_q != S_IDLE);
        cpu_rst_n     = (state_q == S_RUN);
        cpu_start     = (state_q == S_RUN);
    end

    assign accept   = (state_q == S_LOAD) && host.in_valid;
    assign out_hs   = out_valid_q && host.out_ready;
    assign out_load = rd_vld_q && (!out_valid_q || host.out_ready);
    // Read slot plus output register act as a two-entry pipe, so a stall never drops a word
    assign issue    = (state_q == S_DUMP) && !ptr_q[ADDR_W] && (!rd_vld_q || out_load);

    always_comb begin
        ptr_d        = ptr_q;
        run_cycles_d = run_cycles_q;
        we           = 1'b0;
        waddr        = ptr_q[ADDR_W-1:0];
        wdata        = host.in_data;
        rd_en        = 1'b0;
        rd_addr      = ptr_q[ADDR_W-1:0];
        case (state_q)
            S_IDLE:  ptr_d = '0;
            S_CLEAR: begin
                we    = 1'b1;
                wdata = 8'h00;
                ptr_d = (state_d == S_LOAD) ? '0 : ptr_q + (ADDR_W+1)'(1);
            end
            S_LOAD: begin
                we = accept;
                if (accept) ptr_d = ptr_q + (ADDR_W+1)'(1);
            end
            S_RUN: begin
                ptr_d   = '0;
                we      = cpu_we;
                waddr   = cpu_addr;
                wdata   = cpu_wdata;
                rd_en   = 1'b1;
                rd_addr = cpu_addr;
            end
            S_DUMP: begin
                rd_en = issue;
                if (issue) ptr_d = ptr_q + (ADDR_W+1)'(1);
            end
            default: ptr_d = '0;
        endcase

        if (state_q != S_RUN && state_d == S_RUN)
            run_cycles_d = '0;
        else if (state_q == S_RUN && run_cycles_q != '1)
            run_cycles_d = run_cycles_q + CYC_W'(1);

        rd_vld_d    = (state_q == S_DUMP) && (issue || (rd_vld_q && !out_load));
        rd_last_d   = issue ? (ptr_q[ADDR_W-1:0] == LAST_A) : rd_last_q;
        out_valid_d = (state_q == S_DUMP) && (out_load || (out_valid_q && !host.out_ready));
        out_data_d  = out_load ? rd_q : out_data_q;
        out_last_d  = out_load ? rd_last_q : (out_valid_d ? out_last_q : 1'b0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q        <= '0;
            run_cycles_q <= '0;
            rd_vld_q     <= 1'b0;
            rd_last_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            run_cycles_q <= run_cycles_d;
            rd_vld_q     <= rd_vld_d;
            rd_last_q    <= rd_last_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
        end
    end

    // RAM contents survive reset; a same-address read during write sees the old byte
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        rd_q <= '0;
        else if (rd_en) rd_q <= mem[rd_addr];
    end

    assign cpu_rdata      = rd_q;
    assign run_cycles     = run_cycles_q;
    assign host.out_valid = out_valid_q;
    assign host.out_data  = out_data_q;
    assign host.out_last  = out_last_q;
endmodule

// File: tb/tb_byte_mem_loader.sv
// Directed bench for byte_mem_loader: abort, load/run/dump flows, stalls, optional clear pass.
module tb_byte_mem_loader;
    localparam int DEPTH = 32;
`ifdef CLEAR_ON_LOAD_EN
    localparam int EXP_CLR = 32;
    localparam bit CLR     = 1'b1;
`else
    localparam int EXP_CLR = 0;
    localparam bit CLR     = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_req = 1'b0;
    logic        cpu_rst_n, cpu_start;
    logic        cpu_halt = 1'b0;
    logic        cpu_we = 1'b0;
    logic [4:0]  cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic [7:0]  cpu_rdata;
    logic        busy;
    logic [15:0] run_cycles;

    byte_mem_loader_if h();

    byte_mem_loader #(.ADDR_W(5), .CYC_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_req   (load_req),
        .host       (h),
        .cpu_rst_n  (cpu_rst_n),
        .cpu_start  (cpu_start),
        .cpu_halt   (cpu_halt),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .busy       (busy),
        .run_cycles (run_cycles)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_mem [DEPTH];
    logic [7:0] ld_buf  [DEPTH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Starts from IDLE at a negedge, returns at the negedge after the last accept
    task automatic do_load(input int n, input bit use_last);
        int cnt = 0;
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        while (!h.in_ready && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        chk("clr_cyc", 32'(cnt), 32'(EXP_CLR));
        if (CLR) for (int i = 0; i < DEPTH; i++) exp_mem[i] = 8'h00;
        for (int i = 0; i < n; i++) begin
            h.in_valid = 1'b1;
            h.in_data  = ld_buf[i];
            h.in_last  = use_last && (i == n-1);
            cnt = 0;
            while (!h.in_ready && cnt < 100) begin
                cnt++;
                @(negedge clk);
            end
            exp_mem[i] = ld_buf[i];
            @(negedge clk);
        end
        h.in_valid = 1'b0;
        h.in_last  = 1'b0;
    endtask

    // Core stand-in: halt held in cycle 1 (must be ignored), real halt in cycle k
    task automatic run_to_halt(input int k);
        chk("run_entry", 32'({cpu_rst_n, cpu_start}), 32'h3);
        for (int c = 1; c <= k; c++) begin
            cpu_halt = (c == 1) || (c == k);
            load_req = (c == 2);
            if (c == k) chk("start_at_halt", 32'(cpu_start), 32'h1);
            @(negedge clk);
        end
        cpu_halt = 1'b0;
        load_req = 1'b0;
        chk("halt_stop", 32'({cpu_rst_n, cpu_start}), 32'h0);
        chk("run_cycles", 32'(run_cycles), 32'(k));
    endtask

    // Called at the negedge of the first DUMP cycle
    task automatic dump(input bit tog);
        int         k = 0;
        int         cyc = 0;
        int         last_hs = 0;
        logic       stalled = 1'b0;
        logic [7:0] held = '0;
        while (k < DEPTH && cyc < 400) begin
            h.out_ready = tog ? (cyc % 2 == 1) : 1'b1;
            if (cyc == 0 || cyc == 1) chk("dump_lat0", 32'(h.out_valid), 32'h0);
            if (cyc == 2) chk("dump_lat2", 32'(h.out_valid), 32'h1);
            if (h.out_valid) begin
                if (stalled) chk("dump_hold", 32'(h.out_data), 32'(held));
                if (h.out_ready) begin
                    chk("dump_data", 32'(h.out_data), 32'(exp_mem[k]));
                    chk("dump_last", 32'(h.out_last), 32'(k == DEPTH-1));
                    k++;
                    last_hs = cyc;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = h.out_data;
                end
            end
            @(negedge clk);
            cyc++;
        end
        h.out_ready = 1'b0;
        chk("dump_count", 32'(k), 32'(DEPTH));
        if (!tog) chk("dump_nobubble", 32'(last_hs), 32'(DEPTH+1));
        chk("dump_end", 32'({h.out_valid, busy}), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] old31;
        h.in_valid  = 1'b0;
        h.in_data   = '0;
        h.in_last   = 1'b0;
        h.out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready_busy", 32'({h.in_ready, busy}), 32'h0);
        chk("rst_cpu", 32'({cpu_rst_n, cpu_start}), 32'h0);
        chk("rst_out", 32'({h.out_valid, h.out_last, h.out_data}), 32'h0);
        chk("rst_rdata", 32'(cpu_rdata), 32'h0);
        chk("rst_runcyc", 32'(run_cycles), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Abort a load after three bytes with an async reset
        for (int i = 0; i < DEPTH; i++) ld_buf[i] = 8'(i + 8'h40);
        do_load(3, 1'b0);
        chk("mid_load_ready", 32'(h.in_ready), 32'h1);
        rst = 1'b1;
        #1;
        chk("abort_same_cyc", 32'({h.in_ready, busy, cpu_rst_n}), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Full 32-byte load without in_last; 33rd byte refused
        for (int i = 0; i < DEPTH; i++) ld_buf[i] = 8'(i * 7 + 3);
        do_load(DEPTH, 1'b0);
        h.in_valid = 1'b1;
        h.in_data  = 8'hEE;
        chk("no_33rd", 32'(h.in_ready), 32'h0);
        run_to_halt(2);
        h.in_valid = 1'b0;
        dump(1'b0);

        // Program LD 4; ST 31; halt with data byte 0x5A at address 4
        ld_buf[0] = 8'h84; ld_buf[1] = 8'hBF; ld_buf[2] = 8'hFF;
        ld_buf[3] = 8'h00; ld_buf[4] = 8'h5A;
        do_load(5, 1'b1);
        chk("t2_entry", 32'(cpu_start), 32'h1);
        cpu_addr = 5'd4;
        @(negedge clk);
        chk("t2_ld4", 32'(cpu_rdata), 32'h5A);
        old31     = exp_mem[31];
        cpu_we    = 1'b1;
        cpu_addr  = 5'd31;
        cpu_wdata = 8'h5A;
        exp_mem[31] = 8'h5A;
        @(negedge clk);
        chk("t2_rdw_old", 32'(cpu_rdata), 32'(old31));
        cpu_halt  = 1'b1;
        cpu_addr  = 5'd30;
        cpu_wdata = 8'h3C;
        exp_mem[30] = 8'h3C;
        @(negedge clk);
        cpu_halt = 1'b0;
        cpu_we   = 1'b0;
        chk("t2_halt", 32'({cpu_rst_n, cpu_start}), 32'h0);
        chk("t2_runcyc", 32'(run_cycles), 32'h3);
        dump(1'b1);

        // Fill with 0xAA, then reload two bytes; tail is 0x00 only with the clear pass
        for (int i = 0; i < DEPTH; i++) ld_buf[i] = 8'hAA;
        do_load(DEPTH, 1'b0);
        run_to_halt(2);
        dump(1'b0);
        ld_buf[0] = 8'h11;
        ld_buf[1] = 8'h22;
        do_load(2, 1'b1);
        chk("t5_word2_model", 32'(exp_mem[2]), CLR ? 32'h00 : 32'hAA);
        run_to_halt(13);
        dump(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
